app_packet_rx: RTL and testbench
================================

Name: app_packet_rx

Overview:
- Receive side of the application-layer link. Consumes the byte stream from the PHY/link receiver and finds the SYNC byte.
- Assembles a 32-bit payload (MSB byte first) and checks the trailing CRC-8 (DVB-S2, poly 0xD5).
- Presents each verified payload to application logic with a one-cycle valid pulse. Counts good and bad frames.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker byte value.
- TIMEOUT_CYCLES, 1024, maximum idle clk cycles between bytes inside a frame; 0 disables the timeout.
- CNT_WIDTH, 16, width of the good and bad frame counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_byte  input  8  received byte; sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- payload  output  32  last verified payload; held between frames.
- payload_valid  output  1  one-cycle pulse when payload updates.
- crc_err  output  1  one-cycle pulse on CRC mismatch.
- timeout_err  output  1  one-cycle pulse on inter-byte timeout abort.
- busy  output  1  high while in the DATA or CRC state.
- good_count  output  CNT_WIDTH  saturating count of verified frames.
- bad_count  output  CNT_WIDTH  saturating count of CRC and timeout failures.

Behaviour:
- Reset (async, rst_n=0): state IDLE. payload=0, all pulses 0, busy=0, both counts 0. Byte index, running CRC, shift register and timer are all cleared. Reset mid-frame discards the partial frame with no error pulse.
- Frame format: SYNC_BYTE, then D3 D2 D1 D0 (payload[31:24] first), then CRC.
- CRC definition: CRC-8, poly 0xD5, init 0x00, no reflection, no final XOR, computed over D3..D0 only. Computed incrementally one byte per accepted byte: crc_next = f(crc ^ byte), where f is the 0xD5 bytewise update (table or 8-step shift).
- IDLE: on rx_valid && rx_byte==SYNC_BYTE, go to DATA with index=0, crc=0, timer=0. Any other byte is ignored.
- DATA: each rx_valid shifts the byte into the internal shift register (left by 8), updates crc, increments index, and clears the timer. The 4th byte moves the FSM to CRC. A byte equal to SYNC_BYTE inside DATA is payload data; there is no resync.
- CRC state: on rx_valid, compare rx_byte with the running crc and return to IDLE in the same edge.
  - Match: next cycle payload<=shift register, payload_valid=1, good_count+1.
  - Mismatch: next cycle crc_err=1, bad_count+1, payload unchanged.
- Latency: payload_valid rises exactly 1 clk after the cycle in which the CRC byte is sampled.
- Back-to-back frames: the FSM is already IDLE in the cycle of the output pulse. A SYNC byte arriving that cycle, or the cycle right after the CRC byte, starts a new frame. No dead cycle is required.
- Timeout: in DATA or CRC, the timer increments on every cycle without rx_valid. When timer==TIMEOUT_CYCLES-1 and rx_valid=0:
  - abort to IDLE,
  - timeout_err pulses next cycle,
  - bad_count increments.
  rx_valid in that same cycle takes priority: the byte is accepted and there is no abort. The timer is inactive in IDLE.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap. The pulse outputs are mutually exclusive.
- busy=1 exactly when the state is DATA or CRC; it is registered from the state.

Test Plan:
- Feed A5 00 00 00 01 D5 on consecutive cycles -> payload_valid 1 clk after D5 with payload=0x00000001, good_count=1, crc_err=0.
- Feed A5 00 00 01 00 0B -> payload=0x00000100, valid pulse. Then repeat with CRC byte 0C -> crc_err pulse, payload stays 0x00000100, bad_count=1.
- Feed 11 22 A5 00 00 00 00 00 -> leading 11 and 22 ignored; payload=0x00000000 valid. Also A5 A5 A5 A5 A5 + correct CRC -> payload=0xA5A5A5A5 accepted.
- TIMEOUT_CYCLES=8: feed A5 12 then stall -> timeout_err after 8 idle cycles, busy drops, bad_count=1. Then a full valid frame -> accepted.
- Two frames back-to-back with zero gap (A5..D5 A5..D5) -> two payload_valid pulses 6 cycles apart, good_count=2.
- Assert rst_n=0 after A5 00 00 -> all outputs 0 immediately. After release, the trailing 00 01 D5 is ignored (no pulses).

Source files
------------

// File: rtl/app_packet_rx.sv
// Receive side of the application link: finds SYNC, assembles a 32-bit payload
// MSB byte first, verifies the trailing CRC-8 (poly 0xD5) and counts good/bad frames.
module app_packet_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    output logic [31:0]          payload,
    output logic                 payload_valid,
    output logic                 crc_err,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] bad_count
);

    localparam int          TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [7:0]             crc_q, crc_d;
    logic [31:0]            shreg_q, shreg_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [31:0]            payload_q, payload_d;
    logic                   pv_q, pv_d;
    logic                   ce_q, ce_d;
    logic                   te_q, te_d;
    logic                   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]   good_q, good_d;
    logic [CNT_WIDTH-1:0]   bad_q, bad_d;
    logic                   good_inc, bad_inc;
    logic                   timeout_hit;

    // Bytewise MSB-first CRC-8 update, poly 0xD5.
    function automatic logic [7:0] crc8_upd(input logic [7:0] x);
        logic [7:0] c;
        c = x;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'hD5) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // An arriving byte always wins over a timeout in the same cycle.
    assign timeout_hit = TO_EN && !rx_valid && (timer_q == TMAX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        crc_d     = crc_q;
        shreg_d   = shreg_q;
        timer_d   = timer_q;
        payload_d = payload_q;
        pv_d      = 1'b0;
        ce_d      = 1'b0;
        te_d      = 1'b0;
        good_inc  = 1'b0;
        bad_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = S_DATA;
                    idx_d   = 2'd0;
                    crc_d   = 8'h00;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    shreg_d = {shreg_q[23:0], rx_byte};
                    crc_d   = crc8_upd(crc_q ^ rx_byte);
                    idx_d   = idx_q + 2'd1;
                    timer_d = '0;
                    if (idx_q == 2'd3) state_d = S_CRC;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    te_d    = 1'b1;
                    bad_inc = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = TO_EN ? timer_q + TW'(1) : '0;
                end
            end
            S_CRC: begin
                if (rx_valid) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    if (rx_byte == crc_q) begin
                        payload_d = shreg_q;
                        pv_d      = 1'b1;
                        good_inc  = 1'b1;
                    end else begin
                        ce_d    = 1'b1;
                        bad_inc = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    te_d    = 1'b1;
                    bad_inc = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = TO_EN ? timer_q + TW'(1) : '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        good_d = (good_inc && good_q != '1) ? good_q + CNT_WIDTH'(1) : good_q;
        bad_d  = (bad_inc  && bad_q  != '1) ? bad_q  + CNT_WIDTH'(1) : bad_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            crc_q     <= '0;
            shreg_q   <= '0;
            timer_q   <= '0;
            payload_q <= '0;
            pv_q      <= 1'b0;
            ce_q      <= 1'b0;
            te_q      <= 1'b0;
            busy_q    <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            crc_q     <= crc_d;
            shreg_q   <= shreg_d;
            timer_q   <= timer_d;
            payload_q <= payload_d;
            pv_q      <= pv_d;
            ce_q      <= ce_d;
            te_q      <= te_d;
            busy_q    <= busy_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign payload       = payload_q;
    assign payload_valid = pv_q;
    assign crc_err       = ce_q;
    assign timeout_err   = te_q;
    assign busy          = busy_q;
    assign good_count    = good_q;
    assign bad_count     = bad_q;

endmodule

// File: tb/tb_app_packet_rx.sv
// Directed bench for app_packet_rx: CRC pass/fail, hunting, timeout, back-to-back,
// counter saturation (narrow-counter instance) and mid-frame reset.
module tb_app_packet_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic [31:0] payload;
    logic        payload_valid, crc_err, timeout_err, busy;
    logic [15:0] good_count, bad_count;

    logic [31:0] s_payload;
    logic        s_payload_valid, s_crc_err, s_timeout_err, s_busy;
    logic [1:0]  s_good, s_bad;

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    app_packet_rx #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .payload(payload), .payload_valid(payload_valid), .crc_err(crc_err),
        .timeout_err(timeout_err), .busy(busy),
        .good_count(good_count), .bad_count(bad_count)
    );

    app_packet_rx #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .payload(s_payload), .payload_valid(s_payload_valid), .crc_err(s_crc_err),
        .timeout_err(s_timeout_err), .busy(s_busy),
        .good_count(s_good), .bad_count(s_bad)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present a byte for one edge; return #1 after the edge that samples it.
    task automatic drive(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input logic [7:0] crc);
        drive(8'hA5);
        drive(d[31:24]);
        drive(d[23:16]);
        drive(d[15:8]);
        drive(d[7:0]);
        drive(crc);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_payload", payload, 32'h0);
        chk("rst_pulses", 32'({payload_valid, crc_err, timeout_err}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_good", 32'(good_count), 32'h0);
        chk("rst_bad", 32'(bad_count), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Frame 1: 00000001, CRC D5; busy tracks DATA/CRC
        drive(8'hA5);
        chk("f1_busy_after_sync", 32'(busy), 32'h1);
        drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h01);
        chk("f1_busy_in_crc", 32'(busy), 32'h1);
        chk("f1_no_early_valid", 32'(payload_valid), 32'h0);
        drive(8'hD5);
        chk("f1_valid", 32'(payload_valid), 32'h1);
        chk("f1_payload", payload, 32'h0000_0001);
        chk("f1_crc_err", 32'(crc_err), 32'h0);
        chk("f1_good", 32'(good_count), 32'h1);
        chk("f1_busy_drop", 32'(busy), 32'h0);
        idle(1);
        chk("f1_pulse_one_cycle", 32'(payload_valid), 32'h0);

        // Frame 2: 00000100, CRC 0B
        send_frame(32'h0000_0100, 8'h0B);
        chk("f2_valid", 32'(payload_valid), 32'h1);
        chk("f2_payload", payload, 32'h0000_0100);
        chk("f2_good", 32'(good_count), 32'h2);
        idle(1);

        // Frame 3: same data, wrong CRC 0C
        send_frame(32'h0000_0100, 8'h0C);
        chk("f3_crc_err", 32'(crc_err), 32'h1);
        chk("f3_no_valid", 32'(payload_valid), 32'h0);
        chk("f3_payload_held", payload, 32'h0000_0100);
        chk("f3_bad", 32'(bad_count), 32'h1);
        chk("f3_good_held", 32'(good_count), 32'h2);
        idle(1);
        chk("f3_err_one_cycle", 32'(crc_err), 32'h0);

        // Leading junk ignored, then all-zero frame
        drive(8'h11); drive(8'h22);
        chk("hunt_not_busy", 32'(busy), 32'h0);
        send_frame(32'h0000_0000, 8'h00);
        chk("f4_valid", 32'(payload_valid), 32'h1);
        chk("f4_payload", payload, 32'h0000_0000);
        chk("f4_good", 32'(good_count), 32'h3);
        idle(1);

        // SYNC value inside data is payload, CRC 05
        send_frame(32'hA5A5_A5A5, 8'h05);
        chk("f5_valid", 32'(payload_valid), 32'h1);
        chk("f5_payload", payload, 32'hA5A5_A5A5);
        chk("f5_good", 32'(good_count), 32'h4);
        idle(1);

        // Timeout: A5 12 then stall
        drive(8'hA5); drive(8'h12);
        rx_valid = 1'b0;
        cyc = 0;
        while (cyc < 20 && !timeout_err) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("to_cycles", 32'(cyc), 32'd8);
        chk("to_pulse", 32'(timeout_err), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_bad", 32'(bad_count), 32'h2);
        chk("to_no_valid", 32'(payload_valid), 32'h0);
        idle(1);
        chk("to_one_cycle", 32'(timeout_err), 32'h0);

        // Bytes landing exactly on the last timer cycle are accepted
        drive(8'hA5); idle(7);
        drive(8'h00); idle(7);
        drive(8'h00); idle(7);
        drive(8'h00); idle(7);
        drive(8'h01); idle(7);
        chk("edge_still_busy", 32'(busy), 32'h1);
        drive(8'hD5);
        chk("edge_valid", 32'(payload_valid), 32'h1);
        chk("edge_payload", payload, 32'h0000_0001);
        chk("edge_bad_held", 32'(bad_count), 32'h2);
        chk("edge_good", 32'(good_count), 32'h5);
        idle(1);

        // Back-to-back, zero gap
        send_frame(32'h0000_0001, 8'hD5);
        chk("b2b_valid1", 32'(payload_valid), 32'h1);
        chk("b2b_good1", 32'(good_count), 32'h6);
        send_frame(32'h0000_0100, 8'h0B);
        chk("b2b_valid2", 32'(payload_valid), 32'h1);
        chk("b2b_payload2", payload, 32'h0000_0100);
        chk("b2b_good2", 32'(good_count), 32'h7);
        idle(1);

        // Two more CRC failures to push the narrow bad counter into saturation
        send_frame(32'h0000_0001, 8'h00);
        chk("bad4_err", 32'(crc_err), 32'h1);
        idle(1);
        send_frame(32'h0000_0001, 8'h00);
        chk("bad5_err", 32'(crc_err), 32'h1);
        chk("bad_total", 32'(bad_count), 32'h4);
        idle(1);
        chk("sat_good", 32'(s_good), 32'h3);
        chk("sat_bad", 32'(s_bad), 32'h3);
        chk("sat_payload", s_payload, 32'h0000_0100);
        chk("sat_flags", 32'({s_payload_valid, s_crc_err, s_timeout_err, s_busy}), 32'h0);

        // Reset mid-frame discards the partial frame
        drive(8'hA5); drive(8'h00); drive(8'h00);
        chk("mr_busy", 32'(busy), 32'h1);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_payload", payload, 32'h0);
        chk("mr_flags", 32'({payload_valid, crc_err, timeout_err, busy}), 32'h0);
        chk("mr_good", 32'(good_count), 32'h0);
        chk("mr_bad", 32'(bad_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(8'h00);
        chk("mr_tail0", 32'({payload_valid, crc_err, timeout_err, busy}), 32'h0);
        drive(8'h01);
        chk("mr_tail1", 32'({payload_valid, crc_err, timeout_err, busy}), 32'h0);
        drive(8'hD5);
        chk("mr_tail2", 32'({payload_valid, crc_err, timeout_err, busy}), 32'h0);
        idle(10);
        chk("mr_quiet", 32'({payload_valid, crc_err, timeout_err, busy}), 32'h0);
        chk("mr_counts", 32'({good_count, bad_count}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
